// File: rtl/rom_rd_pkg.sv
// -----------------------------------------------------------------------------
// rom_rd_pkg
// Shared types and constants for the ROM stream reader slice.
//   rd_state_e : sequencer state (IDLE, RUN, DRAIN)
//   FIFO_DEPTH : entries in the return-data buffer
// -----------------------------------------------------------------------------
package rom_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } rd_state_e;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/rom_stream_reader_if.sv
// -----------------------------------------------------------------------------
// rom_stream_reader_if
// Valid/ready word stream leaving the reader.
//   m_valid : word valid          (master -> slave)
//   m_data  : stream word         (master -> slave)
//   m_last  : final word of burst (master -> slave)
//   m_ready : consumer ready      (slave  -> master)
// -----------------------------------------------------------------------------
interface rom_stream_reader_if #(
  parameter int DW = 16
);

  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/sync_fifo2.sv
// -----------------------------------------------------------------------------
// sync_fifo2
// Two-entry single-clock FIFO holding words returned by the ROM.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write a word (caller guarantees not full)
//   pop        : drop the head word (caller guarantees not empty)
//   dout       : head word
//   empty      : no words held
//   count      : words held, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module sync_fifo2
  import rom_rd_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;

  // NOTE: the storage is only two words, so it is reset along with the
  // pointers; that makes the head word (and m_data) read 0 out of reset.
  // NOTE: every register here is written with <= so all updates in a clock
  // edge see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/rom_stream_reader.sv
// -----------------------------------------------------------------------------
// rom_stream_reader
// Reads len words from a ROM port starting at start_addr (address wraps mod
// 2**AW), hides the ROM's one-cycle read latency and delivers the words as a
// valid/ready stream.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : request pulse, honoured only while busy=0
//   start_addr, len       : first address and word count (0..2**AW)
//   busy, done            : transfer in progress / one-cycle end pulse
//   rom_en, rom_addr      : ROM read request
//   rom_dout              : ROM data, valid the cycle after rom_en
//   m                     : output stream (master side)
// -----------------------------------------------------------------------------
module rom_stream_reader
  import rom_rd_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout,
  rom_stream_reader_if.master m
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  rd_state_e     state;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [AW:0]   issued_q;
  logic [AW:0]   out_cnt_q;
  logic          inflight_q;   // a read was issued last cycle; its word lands now

  logic          empty;
  logic [1:0]    count;
  logic [DW-1:0] head;
  logic          pop;
  logic [2:0]    committed;

  sync_fifo2 #(.DW(DW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .din   (rom_dout),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .count (count)
  );

  assign pop = ~empty & m.m_ready;

  // Slots already claimed once this cycle's pop is taken into account. A pop
  // can only happen with count>=1, so this never underflows.
  assign committed = {1'b0, count} + 3'(inflight_q) - 3'(pop);

  // The issue decision has to see this cycle's pop to sustain one word per
  // cycle through a two-entry buffer, so rom_en is decoded from registered
  // state plus the consumer's ready rather than registered itself.
  assign rom_en   = (state == RUN) && (issued_q != len_q) &&
                    (committed < 3'(FIFO_DEPTH));
  assign rom_addr = base_q + issued_q[AW-1:0];

  assign busy     = (state != IDLE);

  assign m.m_valid = ~empty;
  assign m.m_data  = head;
  assign m.m_last  = ~empty && (out_cnt_q == len_q - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      inflight_q <= rom_en;
      if (rom_en) issued_q  <= issued_q + ONE;
      if (pop)    out_cnt_q <= out_cnt_q + ONE;

      case (state)
        IDLE: begin
          if (start) begin
            base_q    <= start_addr;
            len_q     <= len;
            issued_q  <= '0;
            out_cnt_q <= '0;
            if (len == '0) done  <= 1'b1;
            else           state <= RUN;
          end
        end
        RUN: begin
          if (rom_en && (issued_q + ONE == len_q)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m.m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_rom_stream_reader
// Bench for rom_stream_reader against a ROM holding mem[i] = 16'hA000 + i.
// A transaction-level model (queues of expected addresses and words) is
// compared with the DUT on every falling edge; directed tests add literal
// expectations for cycle timing, wrap, backpressure, control edges and reset.
// -----------------------------------------------------------------------------
module tb_rom_stream_reader;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy;
  logic          done;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout = '0;

  rom_stream_reader_if #(.DW(DW)) m_if ();

  rom_stream_reader #(.AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .m          (m_if)
  );

  always #5 clk = ~clk;

  // Registered-read ROM, contents A000 + address.
  always @(posedge clk) begin
    if (rom_en) rom_dout <= 16'hA000 + 16'(rom_addr);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [DW-1:0] exp_q  [$];   // words still to be delivered, in order
  logic [AW-1:0] addr_q [$];   // addresses still to be read, in order
  logic [DW-1:0] dlog   [$];   // words actually handed over
  bit            m_active = 1'b0;
  bit            m_done   = 1'b0;
  int            issued_tot = 0;
  int            popped_tot = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      addr_q.delete();
      m_active   = 1'b0;
      m_done     = 1'b0;
      issued_tot = 0;
      popped_tot = 0;
    end else begin : cmp
      bit            act_now;
      bit            nxt_done;
      logic [AW-1:0] a;
      act_now  = m_active;
      nxt_done = 1'b0;

      check("busy", busy, m_active);
      check("done", done, m_done);

      if (m_if.m_valid) begin
        if (exp_q.size() == 0) check("valid_without_word", m_if.m_valid, 0);
        else begin
          check("m_data", m_if.m_data, exp_q[0]);
          check("m_last", m_if.m_last, exp_q.size() == 1);
        end
      end

      if (rom_en) begin
        if (addr_q.size() == 0) check("rom_en_unexpected", rom_en, 0);
        else begin
          check("rom_addr", rom_addr, addr_q.pop_front());
          issued_tot++;
        end
      end

      if (m_if.m_valid && m_if.m_ready && exp_q.size() != 0) begin
        dlog.push_back(m_if.m_data);
        void'(exp_q.pop_front());
        popped_tot++;
        if (exp_q.size() == 0) begin
          m_active = 1'b0;
          nxt_done = 1'b1;
        end
      end

      if (rom_en) check("outstanding_le_2", (issued_tot - popped_tot) <= 2, 1);

      if (start && !act_now) begin
        if (len == '0) nxt_done = 1'b1;
        else begin
          m_active = 1'b1;
          for (int i = 0; i < int'(len); i++) begin
            a = start_addr + AW'(i);
            addr_q.push_back(a);
            exp_q.push_back(16'hA000 + 16'(a));
          end
        end
      end
      m_done = nxt_done;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Start high during "cycle 0"; returns 1 time unit into cycle 1.
  task automatic kick(input logic [AW-1:0] a, input logic [AW:0] l);
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_finished_in_time"}, k < 200, 1);
    check({tag, "_words_left"}, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_rom_en"},   rom_en, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_m_valid"},  m_if.m_valid, 0);
    check({tag, "_m_data"},   m_if.m_data, 0);
    check({tag, "_m_last"},   m_if.m_last, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] t2_exp [4];
    int            stall_en;
    t2_exp = '{16'hA00E, 16'hA00F, 16'hA000, 16'hA001};
    m_if.m_ready = 1'b1;

    // ---- reset state ----
    #12;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- test 1: full 16-word burst, exact cycle timing ----
    dlog.delete();
    kick(4'd0, 5'd16);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      check("t1_rom_en", rom_en, c <= 16);
      if (rom_en) check("t1_rom_addr", rom_addr, c - 1);
      check("t1_m_valid", m_if.m_valid, (c >= 3) && (c <= 18));
      if ((c >= 3) && (c <= 18)) check("t1_m_data", m_if.m_data, 16'hA000 + c - 3);
      check("t1_m_last", m_if.m_last, c == 18);
      check("t1_done", done, c == 19);
      check("t1_busy", busy, (c >= 1) && (c <= 18));
    end
    wait_idle("t1");
    check("t1_count", dlog.size(), 16);

    // ---- test 2: address wrap ----
    dlog.delete();
    kick(4'd14, 5'd4);
    wait_idle("t2");
    check("t2_count", dlog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < dlog.size()) check("t2_word", dlog[i], t2_exp[i]);

    // ---- test 3: backpressure, stall cycles 4..9 then toggling ----
    dlog.delete();
    stall_en = 0;
    kick(4'd2, 5'd8);
    for (int c = 1; c <= 40; c++) begin
      m_if.m_ready = (c < 4) ? 1'b1 : (c <= 9) ? 1'b0 : 1'(c % 2);
      @(negedge clk);
      if ((c >= 4) && (c <= 9)) begin
        if (rom_en) stall_en++;
        check("t3_stall_valid", m_if.m_valid, 1);
        check("t3_stall_data", m_if.m_data, 16'hA003);
      end
      @(posedge clk); #1;
    end
    m_if.m_ready = 1'b1;
    check("t3_stall_rom_en_le_2", stall_en <= 2, 1);
    wait_idle("t3");
    check("t3_count", dlog.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < dlog.size()) check("t3_word", dlog[i], 16'hA002 + i);

    // ---- test 4a: zero-length request ----
    kick(4'd7, 5'd0);
    @(negedge clk);
    check("t4a_done", done, 1);
    check("t4a_busy", busy, 0);
    check("t4a_rom_en", rom_en, 0);
    @(negedge clk);
    check("t4a_done_gone", done, 0);
    check("t4a_busy_still0", busy, 0);
    @(posedge clk); #1;

    // ---- test 4b: second start while busy is ignored ----
    dlog.delete();
    kick(4'd5, 5'd3);
    start = 1'b1; start_addr = 4'd9; len = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("t4b");
    check("t4b_count", dlog.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < dlog.size()) check("t4b_word", dlog[i], 16'hA005 + i);

    // ---- test 5: reset mid-run, then a clean 2-word transfer ----
    dlog.delete();
    kick(4'd0, 5'd16);
    repeat (5) @(posedge clk);     // now at the start of cycle 6
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t5_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    dlog.delete();
    kick(4'd3, 5'd2);
    wait_idle("t5");
    check("t5_count", dlog.size(), 2);
    if (dlog.size() > 0) check("t5_word0", dlog[0], 16'hA003);
    if (dlog.size() > 1) check("t5_word1", dlog[1], 16'hA004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Read-side sequencer for the single-port view of `rom_dual_port`. It takes a start address and a word count, issues ROM reads, and absorbs the ROM's one-cycle registered read latency. Words are delivered as a valid/ready stream, so a stalling consumer never loses data. One instance sits on each ROM port that feeds a streaming datapath.

## Interface
- `AW`, 4: ROM address width.
- `DW`, 16: ROM data width.
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request pulse; accepted only while `busy`=0.
- `start_addr`  in  AW: first ROM address, sampled with `start`.
- `len`  in  AW+1: words to read, 0..2**AW, sampled with `start`.
- `busy`  out  1: transfer in progress.
- `done`  out  1: one-cycle pulse at transfer end.
- `rom_en`  out  1: ROM read enable.
- `rom_addr`  out  AW: ROM read address.
- `rom_dout`  in  DW: ROM data, valid the cycle after `rom_en`.
- `m_valid`  out  1: stream word valid.
- `m_ready`  in  1: consumer ready.
- `m_data`  out  DW: stream word.
- `m_last`  out  1: final word of the transfer.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE to RUN on `start` with `len`≠0.
  - IDLE with `start` and `len`=0: `done` pulses the next cycle; no `rom_en`; stays in IDLE.
  - RUN to DRAIN when the issued count reaches `len`.
  - DRAIN to IDLE on the handshake of the `m_last` word.
- `busy`=1 in RUN and DRAIN. `start` is ignored while `busy`=1.
- Issue counter, width AW+1: `rom_addr` = (`start_addr` + issued) mod 2**AW, so the address wraps from 2**AW-1 to 0.
- Buffer:
  - 2-entry FIFO holds returned words.
  - A read is issued (`rom_en`=1) only while occupancy + in-flight − same-cycle pop < 2. Counting the same-cycle pop sustains 1 word/cycle with `m_ready` held high.
  - A word is captured into the FIFO the cycle after its `rom_en`.
  - `m_valid` = FIFO not empty; `m_data` = FIFO head.
- Output counter, width AW+1: `m_last`=1 when the head word is word number `len`−1.
- `done` pulses in the cycle after the `m_last` handshake; `busy` deasserts in that same cycle.
- Handshake rule: `m_data` and `m_last` hold stable while `m_valid`=1 and `m_ready`=0.
- Reset (async, any state):
  - Returns to IDLE.
  - Discards FIFO contents and any in-flight read; the ROM word returning after reset is ignored.
  - Outputs take their reset values immediately.

## Timing
- Reset values: `busy`=0, `done`=0, `rom_en`=0, `rom_addr`=0, `m_valid`=0, `m_data`=0, `m_last`=0.
- `start` is sampled in cycle 0.
- `rom_en`=1 with `rom_addr`=`start_addr` in cycle 1.
- `rom_dout` is valid in cycle 2.
- `m_valid` first rises in cycle 3.
- With `m_ready`=1 throughout: word k appears in cycle 3+k, `m_last` in cycle 2+`len`, and `done` in cycle 3+`len`.
- Backpressure: at most 2 reads are outstanding or buffered. When `m_ready` rises again, streaming resumes the next cycle with no bubble beyond refill.

## Structure
- Package `rom_rd_pkg`:
  - `rd_state_e` enum (IDLE, RUN, DRAIN).
  - Localparam `FIFO_DEPTH`=2.
- Sub-module `sync_fifo2`: 2-entry, single-clock FIFO with push, pop, `empty`, `count` and head data, using the same async active-low reset. Everything else is in the top module.

## Test plan
ROM initialised with mem[i] = 16'hA000 + i for all tests.

1. `start_addr`=0, `len`=16, `m_ready`=1 -> `rom_addr` 0..15 in cycles 1..16; `m_data` A000..A00F in cycles 3..18; `m_last` in cycle 18; `done` in cycle 19.
2. Wrap: `start_addr`=14, `len`=4 -> `rom_addr` 14,15,0,1; `m_data` A00E, A00F, A000, A001; `m_last` on A001.
3. Backpressure: `len`=8, `m_ready`=0 during cycles 4..9, then toggling every cycle -> at most 2 `rom_en` pulses during the stall; all 8 words delivered in order with none lost or repeated; `m_data` stable while stalled.
4. Control edges:
   - `len`=0 -> `done` 1 cycle later; no `rom_en`; `busy` stays 0.
   - A second `start` while `busy` is ignored; only the first transfer's words appear.
5. Reset mid-run: assert `rst_n`=0 in cycle 6 of a `len`=16 transfer -> all outputs 0 immediately. A new `start` (`start_addr`=3, `len`=2) after release yields exactly A003, A004 with no stale word.
